// File: rtl/trace_capture.sv
// trace_capture: double-buffered oscilloscope trace capture.
// Samples are captured into the hidden bank after a trigger, and the banks
// swap at the next vertical blank so the display always shows a complete trace.
module trace_capture #(
  parameter int SAMPLE_W   = 8,
  parameter int DEPTH      = 640,
  parameter int TRIG_LEVEL = 128
) (
  input  logic                clk_25MHz,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                frame_start,
  input  logic [9:0]          rd_x,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [1:0]          state,
  output logic                trig_pulse,
  output logic                disp_bank
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [AW-1:0]       LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [SAMPLE_W-1:0] TRIG      = SAMPLE_W'(TRIG_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t              cur_state;
  state_t              next_state;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       wr_addr_next;
  logic [AW-1:0]       wr_idx;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                edge_hit;
  logic                trigger;
  logic                wr_en;
  logic                swap;
  logic                rd_in_range;

  logic [SAMPLE_W-1:0] bank0 [DEPTH];
  logic [SAMPLE_W-1:0] bank1 [DEPTH];

  assign state       = cur_state;
  assign edge_hit    = sample_valid && (prev_sample < TRIG) && (sample_data >= TRIG);
  assign rd_in_range = (32'(rd_x) < 32'(DEPTH));

  // Next-state, write control and bank-swap decision for the capture sequencer.
  always_comb begin
    next_state   = cur_state;
    wr_addr_next = wr_addr;
    wr_idx       = wr_addr;
    trigger      = 1'b0;
    wr_en        = 1'b0;
    swap         = 1'b0;
    if (mode == MODE_FREEZE) begin
      next_state   = S_IDLE;
      wr_addr_next = '0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (mode != MODE_SINGLE || arm) next_state = S_ARMED;
        end
        S_ARMED: begin
          if (sample_valid && (mode == MODE_FREE || edge_hit)) begin
            trigger      = 1'b1;
            wr_en        = 1'b1;
            wr_idx       = '0;
            wr_addr_next = AW'(1);
            next_state   = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            if (wr_addr == LAST_ADDR) begin
              wr_addr_next = '0;
              next_state   = S_DONE;
            end else begin
              wr_addr_next = wr_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (frame_start) begin
            swap       = 1'b1;
            next_state = (mode == MODE_SINGLE) ? S_IDLE : S_ARMED;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Sequencer registers; reset abandons any capture without swapping banks.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      cur_state   <= S_IDLE;
      wr_addr     <= '0;
      prev_sample <= '0;
      trig_pulse  <= 1'b0;
      disp_bank   <= 1'b0;
    end else begin
      cur_state  <= next_state;
      wr_addr    <= wr_addr_next;
      trig_pulse <= trigger;
      disp_bank  <= disp_bank ^ swap;
      if (sample_valid) prev_sample <= sample_data;
    end
  end

  // Capture writes always land in the bank that is not on screen.
  always_ff @(posedge clk_25MHz) begin
    if (wr_en) begin
      if (disp_bank) bank0[wr_idx] <= sample_data;
      else           bank1[wr_idx] <= sample_data;
    end
  end

  // Registered display read from the visible bank; columns past the trace read 0.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= disp_bank ? bank1[rd_x[AW-1:0]] : bank0[rd_x[AW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized scoreboard bench for trace_capture.
// Expected trigger times and trace contents come from scanning the sample
// stream at transaction level; a monitor compares them as the DUT responds.
module tb_trace_capture;

  localparam int SAMPLE_W = 8;
  localparam int DEPTH    = 640;
  localparam int TRIG     = 128;

  logic                clk_25MHz    = 1'b0;
  logic                rst          = 1'b1;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_data  = '0;
  logic [1:0]          mode         = 2'b00;
  logic                arm          = 1'b0;
  logic                frame_start  = 1'b0;
  logic [9:0]          rd_x         = '0;
  logic [SAMPLE_W-1:0] rd_data;
  logic [1:0]          state;
  logic                trig_pulse;
  logic                disp_bank;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int trig_q[$];
  int rd_q[$];
  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;

  int stream[1200];
  int model_mem[2][DEPTH];
  int model_disp  = 0;
  int last_sample = 0;
  int phase       = 0;
  int t;

  trace_capture #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .TRIG_LEVEL(TRIG)) dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .mode        (mode),
    .arm         (arm),
    .frame_start (frame_start),
    .rd_x        (rd_x),
    .rd_data     (rd_data),
    .state       (state),
    .trig_pulse  (trig_pulse),
    .disp_bank   (disp_bank)
  );

  // 25 MHz pixel clock.
  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_25MHz);
    #1;
    cyc++;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Index of the first sample that qualifies as a trigger, or -1.
  function automatic int find_trig(input int prev, input int n, input bit free_run);
    int p;
    p = prev;
    if (free_run) return 0;
    for (int i = 0; i < n; i++) begin
      if (p < TRIG && stream[i] >= TRIG) return i;
      p = stream[i];
    end
    return -1;
  endfunction

  function automatic void fill_random(input int n, input bit force_cross);
    for (int i = 0; i < n; i++) stream[i] = int'($urandom_range(0, 255));
    if (force_cross) begin
      stream[0] = 10;
      stream[1] = 200;
    end
  endfunction

  function automatic void fill_sine(input int n);
    real v;
    int  s;
    for (int i = 0; i < n; i++) begin
      v = 128.0 + 100.0 * $sin(2.0 * 3.14159265 * real'(phase) / 50.0);
      s = int'(v) + int'($urandom_range(0, 2));
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      stream[i] = s;
      phase++;
    end
  endfunction

  // The hidden bank receives the samples from the trigger onward.
  function automatic void capture_model(input int trig_idx, input int n);
    if (trig_idx < 0) return;
    for (int k = 0; k < DEPTH; k++)
      if (trig_idx + k < n) model_mem[1 - model_disp][k] = stream[trig_idx + k];
  endfunction

  // Drives n samples with gap idle cycles between them, queuing the trigger time.
  task automatic apply_stimulus(input int n, input int gap, input int trig_idx, input int fs_idx);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = SAMPLE_W'(stream[i]);
      frame_start  = (i == fs_idx);
      if (i == trig_idx) trig_q.push_back(cyc + 1);
      step();
      sample_valid = 1'b0;
      frame_start  = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    if (n > 0) last_sample = stream[n-1];
  endtask

  task automatic read_range(input int start, input int cnt);
    for (int x = start; x < start + cnt; x++) begin
      rd_x   = 10'(x);
      rd_req = 1'b1;
      rd_q.push_back((x < DEPTH) ? model_mem[model_disp][x] : 0);
      step();
    end
    rd_req = 1'b0;
    step();
  endtask

  // Delay the read-request flag to line up with the registered read data.
  always @(posedge clk_25MHz) rd_req_d <= rd_req;

  // Monitor: pops the scoreboard whenever the DUT presents a trigger or read data.
  initial begin : monitor
    forever begin
      @(negedge clk_25MHz);
      if (trig_pulse === 1'b1) begin
        if (trig_q.size() == 0) check_output("unexpected trig_pulse", cyc, -1);
        else check_output("trig_pulse cycle", cyc, trig_q.pop_front());
      end
      if (rd_req_d) begin
        if (rd_q.size() == 0) check_output("unexpected read", int'(rd_data), -1);
        else check_output("rd_data", int'(rd_data), rd_q.pop_front());
      end
    end
  end

  // Scenario sequence.
  initial begin : stimulus
    mode = 2'b01;
    #5;
    check_output("reset state", int'(state), 0);
    check_output("reset disp_bank", int'(disp_bank), 0);
    check_output("reset rd_data", int'(rd_data), 0);
    check_output("reset trig_pulse", int'(trig_pulse), 0);
    #30 rst = 1'b0;
    #10;
    check_output("no transition before edge", int'(state), 0);
    step();
    check_output("first edge to ARMED", int'(state), 1);

    // Normal trigger on a wrapping ramp, frame_start on the last write.
    for (int i = 0; i < 701; i++) stream[i] = (100 + i) % 256;
    t = find_trig(last_sample, 701, 1'b0);
    apply_stimulus(701, 0, t, t + DEPTH - 1);
    capture_model(t, 701);
    check_output("ramp DONE", int'(state), 3);
    check_output("no swap on last write", int'(disp_bank), 0);
    pulse_frame();
    model_disp ^= 1;
    check_output("ramp swap", int'(disp_bank), 1);
    check_output("ramp rearm", int'(state), 1);
    check_output("ramp column 0", model_mem[model_disp][0], 128);
    read_range(0, DEPTH);

    // Free-run with sparse samples and an early frame_start.
    mode = 2'b00;
    fill_random(DEPTH, 1'b0);
    apply_stimulus(DEPTH, 2, 0, DEPTH - 2);
    capture_model(0, DEPTH);
    check_output("free-run DONE", int'(state), 3);
    check_output("early frame ignored", int'(disp_bank), 1);
    mode = 2'b10;
    pulse_frame();
    model_disp ^= 1;
    check_output("free-run swap", int'(disp_bank), 0);
    check_output("single-shot to IDLE", int'(state), 0);
    read_range(0, DEPTH + 4);

    // Single-shot on a sine: one capture, no re-trigger until armed.
    pulse_arm();
    check_output("arm to ARMED", int'(state), 1);
    fill_sine(1000);
    t = find_trig(last_sample, 1000, 1'b0);
    apply_stimulus(1000, 0, t, -1);
    capture_model(t, 1000);
    check_output("sine DONE", int'(state), 3);
    pulse_arm();
    check_output("arm in DONE ignored", int'(state), 3);
    pulse_frame();
    model_disp ^= 1;
    check_output("sine to IDLE", int'(state), 0);
    check_output("sine swap", int'(disp_bank), 1);
    fill_sine(200);
    apply_stimulus(200, 0, -1, -1);
    check_output("unarmed stays IDLE", int'(state), 0);
    pulse_arm();
    fill_sine(800);
    t = find_trig(last_sample, 800, 1'b0);
    apply_stimulus(800, 0, t, -1);
    capture_model(t, 800);
    pulse_frame();
    model_disp ^= 1;
    check_output("second sine swap", int'(disp_bank), 0);
    read_range(0, DEPTH);

    // Freeze aborts a capture at wr_addr 300.
    mode = 2'b01;
    step();
    check_output("normal to ARMED", int'(state), 1);
    fill_random(1000, 1'b1);
    t = find_trig(last_sample, 1000, 1'b0);
    apply_stimulus(t + 300, 0, t, -1);
    capture_model(t, t + 300);
    check_output("capturing", int'(state), 2);
    mode = 2'b11;
    step();
    check_output("freeze to IDLE", int'(state), 0);
    check_output("freeze keeps bank", int'(disp_bank), 0);
    pulse_frame();
    check_output("frame in IDLE ignored", int'(disp_bank), 0);
    read_range(0, DEPTH);

    // Asynchronous reset at wr_addr 500.
    mode = 2'b01;
    step();
    fill_random(1000, 1'b1);
    t = find_trig(last_sample, 1000, 1'b0);
    apply_stimulus(t + 500, 0, t, -1);
    capture_model(t, t + 500);
    #4 rst = 1'b1;
    #1;
    check_output("async reset state", int'(state), 0);
    check_output("async reset disp_bank", int'(disp_bank), 0);
    check_output("async reset rd_data", int'(rd_data), 0);
    check_output("async reset trig_pulse", int'(trig_pulse), 0);
    model_disp  = 0;
    last_sample = 0;
    #30 rst = 1'b0;
    step();
    check_output("post-reset ARMED", int'(state), 1);
    read_range(700, 1);
    fill_random(700, 1'b1);
    t = find_trig(last_sample, 700, 1'b0);
    apply_stimulus(700, 0, t, -1);
    capture_model(t, 700);
    check_output("post-reset DONE", int'(state), 3);
    pulse_frame();
    model_disp ^= 1;
    check_output("post-reset swap", int'(disp_bank), 1);
    read_range(0, DEPTH);

    step();
    step();
    check_output("trigger queue drained", trig_q.size(), 0);
    check_output("read queue drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
